// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
//   Shared definitions for the load/store unit: RV32I funct3 width codes,
//   the FSM state encoding and the default datapath width.
//   No ports.

package load_store_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align
//   Purely combinational byte-lane steering for the load/store unit.
//   Store half: replicates the store datum across all lanes of its size and
//   builds the byte-enable mask. Load half: picks the addressed lane out of
//   the read word and sign- or zero-extends it.
//   Ports:
//     st_size   in  2   access size of the store (funct3[1:0]: 0 B, 1 H, 2 W)
//     st_off    in  2   aligned byte offset of the store
//     st_data   in  32  rs2 value
//     st_wdata  out 32  lane-replicated write data
//     st_wmask  out 4   byte-enable mask, bit i = lane i
//     ld_funct3 in  3   load funct3 (LB/LH/LW/LBU/LHU)
//     ld_off    in  2   aligned byte offset of the load
//     ld_rdata  in  32  word returned by memory
//     ld_result out 32  extended load result

module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata = st_data;
    st_wmask = 4'b1111;
    case (st_size)
      2'd0: begin
        st_wdata = {4{st_data[7:0]}};
        st_wmask = 4'b0001 << st_off;
      end
      2'd1: begin
        st_wdata = {2{st_data[15:0]}};
        st_wmask = 4'b0011 << {st_off[1], 1'b0};
      end
      default: begin
        st_wdata = st_data;
        st_wmask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_off)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    ld_result = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_result = {24'd0, ld_byte};
      F3_H:    ld_result = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_result = {16'd0, ld_half};
      default: ld_result = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   CPU-side initiator for the word-addressed data memory. Accepts one
//   load/store, issues a single memory request, waits for mem_ack, and
//   returns the extended load result with a one-cycle resp_valid pulse.
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   - misaligned half/word accesses are rejected with resp_err
//     undefined - low address bits are forced to natural alignment
//   Ports:
//     clk, reset(active-low async)
//     req_valid/req_ready, is_load, is_store, funct3, addr, store_data  CPU request
//     resp_valid, load_data, resp_err                                  CPU response
//     mem_req, mem_we, mem_addr, mem_wdata, mem_wmask                  memory request
//     mem_ack, mem_rdata                                               memory reply
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | ready for a request; accept registers the whole request
//   MEM     | mem_req held with stable address/data until mem_ack
//   RESP    | resp_valid pulse for one cycle, then back to IDLE

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              resp_valid,
  output logic [XLEN-1:0]   load_data,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e  state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_is_load;

  logic        req_err;
  logic        misalign;
  logic [1:0]  off_align;
  logic [31:0] wdata_c;
  logic [3:0]  wmask_c;
  logic [31:0] ld_ext;

  // Upper address bits wrap within the memory and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[XLEN-1:ADDR_W+2];

  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (is_load ^ is_store) begin
      if (funct3[1:0] == 2'd1)      misalign = addr[0];
      else if (funct3[1:0] == 2'd2) misalign = |addr[1:0];
    end
`endif
    req_err = (is_load && is_store)
            || (is_load && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7))
            || (is_store && (funct3 > F3_W))
            || misalign;

    // Natural alignment: halves drop addr[0], words drop addr[1:0].
    case (funct3[1:0])
      2'd0:    off_align = addr[1:0];
      2'd1:    off_align = {addr[1], 1'b0};
      default: off_align = 2'd0;
    endcase
  end

  lsu_lane_align u_lane_align (
    .st_size   (funct3[1:0]),
    .st_off    (off_align),
    .st_data   (store_data),
    .st_wdata  (wdata_c),
    .st_wmask  (wmask_c),
    .ld_funct3 (r_funct3),
    .ld_off    (r_off),
    .ld_rdata  (mem_rdata),
    .ld_result (ld_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      load_data  <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      r_funct3   <= '0;
      r_off      <= '0;
      r_is_load  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_funct3  <= funct3;
            r_off     <= off_align;
            r_is_load <= is_load;
            if (req_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              load_data  <= '0;
            end else if (is_load || is_store) begin
              state     <= ST_MEM;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= addr[ADDR_W+1:2];
              mem_wdata <= is_store ? wdata_c : '0;
              mem_wmask <= is_store ? wmask_c : '0;
            end else begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              load_data  <= '0;
            end
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            state      <= ST_RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            load_data  <= r_is_load ? ld_ext : '0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
